// File: rtl/cache_ctrl_pkg.sv
// Shared types and set-array mode encodings for the cache miss controller.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        VICTIM = 3'd2,
        WBACK  = 3'd3,
        FILL   = 3'd4,
        REPLAY = 3'd5,
        RESP   = 3'd6
    } state_t;

    localparam logic [1:0] MODE_READ  = 2'b10;
    localparam logic [1:0] MODE_WRITE = 2'b11;
    localparam logic [1:0] MODE_REQ   = 2'b00;
    localparam logic [1:0] MODE_ALLOC = 2'b01;

    // Byte address of word 'beat' within the line whose base address is line_base.
    function automatic logic [31:0] beat_addr(input logic [31:0] line_base,
                                              input logic [31:0] beat);
        return line_base + (beat << 2);
    endfunction

endpackage

// File: rtl/beat_counter.sv
// Word-beat counter for line writeback/fill; wraps to zero after the last word.
module beat_counter #(
    parameter int WIDTH = 2,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] beat,
    output logic             last
);

    localparam logic [WIDTH-1:0] LAST_BEAT = WIDTH'(WORDS - 1);

    logic [WIDTH-1:0] beat_q;
    logic [WIDTH-1:0] beat_d;

    always_comb begin
        beat_d = beat_q;
        if (clear) begin
            beat_d = '0;
        end else if (inc) begin
            // Explicit wrap keeps a single-word line (WORDS == 1) parked at zero.
            beat_d = last ? '0 : beat_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign beat = beat_q;
    assign last = (beat_q == LAST_BEAT);

endmodule

// File: rtl/cache_miss_fsm.sv
// Sequences one CPU load/store through the set array: lookup, optional dirty
// writeback, line fill from memory, and replay of the original access.
module cache_miss_fsm
    import cache_ctrl_pkg::*;
#(
    parameter int TAG_WIDTH  = 24,
    parameter int SET_WIDTH  = 4,
    parameter int LINE_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,

    output logic                 set_en,
    output logic                 set_tick_en,
    output logic [1:0]           set_mode,
    output logic [31:0]          set_addr,
    output logic [31:0]          set_data,
    input  logic                 set_hit,
    input  logic [31:0]          set_out,
    input  logic                 set_dirty,
    input  logic [TAG_WIDTH-1:0] set_tag,

    output logic                 mem_valid,
    output logic                 mem_write,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_rdata
);

    localparam int          WORDS     = 1 << (LINE_WIDTH - 2);
    localparam int          BEAT_W    = (LINE_WIDTH > 2) ? (LINE_WIDTH - 2) : 1;
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

    state_t                 state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic                   write_q, write_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [TAG_WIDTH-1:0]   vtag_q, vtag_d;

    logic                   beat_clear;
    logic                   beat_inc;
    logic [BEAT_W-1:0]      beat;
    logic                   beat_last;

    logic [31:0]            req_line;
    logic [31:0]            victim_line;
    logic [31:0]            fill_addr;
    logic [31:0]            wb_addr;

    beat_counter #(
        .WIDTH (BEAT_W),
        .WORDS (WORDS)
    ) u_beat (
        .clk   (clk),
        .reset (reset),
        .clear (beat_clear),
        .inc   (beat_inc),
        .beat  (beat),
        .last  (beat_last)
    );

    // The victim line shares the request's set index but carries the victim's tag.
    assign req_line    = {addr_q[31:LINE_WIDTH], {LINE_WIDTH{1'b0}}};
    assign victim_line = {vtag_q, addr_q[LINE_WIDTH +: SET_WIDTH], {LINE_WIDTH{1'b0}}};
    assign fill_addr   = beat_addr(req_line, 32'(beat));
    assign wb_addr     = beat_addr(victim_line, 32'(beat));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            vtag_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            vtag_q  <= vtag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        vtag_d     = vtag_q;
        beat_clear = 1'b0;
        beat_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr & ADDR_MASK;
                    write_d = req_write;
                    wdata_d = req_wdata;
                    state_d = LOOKUP;
                end
            end
            LOOKUP, REPLAY: begin
                if (set_hit) begin
                    rdata_d = write_q ? 32'h0 : set_out;
                    state_d = RESP;
                end else begin
                    state_d = VICTIM;
                end
            end
            VICTIM: begin
                vtag_d     = set_tag;
                beat_clear = 1'b1;
                state_d    = set_dirty ? WBACK : FILL;
            end
            WBACK: begin
                if (mem_ready) begin
                    beat_inc = 1'b1;
                    if (beat_last) begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (mem_ready) begin
                    beat_inc = 1'b1;
                    if (beat_last) begin
                        state_d = REPLAY;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = '0;
        set_en      = 1'b0;
        set_tick_en = 1'b0;
        set_mode    = MODE_READ;
        set_addr    = '0;
        set_data    = '0;
        mem_valid   = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state_q)
            IDLE: begin
                // Held low while reset is asserted so nothing is offered mid-reset.
                req_ready = reset;
            end
            LOOKUP, REPLAY: begin
                set_mode    = write_q ? MODE_WRITE : MODE_READ;
                set_tick_en = 1'b1;
                set_addr    = addr_q;
                set_data    = write_q ? wdata_q : 32'h0;
                set_en      = set_hit;
            end
            VICTIM: begin
                set_mode = MODE_REQ;
                set_addr = addr_q;
            end
            WBACK: begin
                set_mode  = MODE_REQ;
                set_addr  = wb_addr;
                mem_valid = 1'b1;
                mem_write = 1'b1;
                mem_addr  = wb_addr;
                mem_wdata = set_out;
            end
            FILL: begin
                mem_valid = 1'b1;
                mem_addr  = fill_addr;
                set_addr  = fill_addr;
                set_mode  = mem_ready ? MODE_ALLOC : MODE_REQ;
                set_en    = mem_ready;
                set_data  = mem_ready ? mem_rdata : 32'h0;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_miss_fsm.sv
// Directed bench for cache_miss_fsm with a 2-way set-array model and a word memory.
module tb_cache_miss_fsm;

    localparam int TW = 24, SW = 4, LW = 4, WORDS = 4, NWAY = 2, NSET = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        set_en, set_tick_en;
    logic [1:0]  set_mode;
    logic [31:0] set_addr, set_data;
    logic        set_hit;
    logic [31:0] set_out;
    logic        set_dirty;
    logic [TW-1:0] set_tag;
    logic        mem_valid, mem_write, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    cache_miss_fsm #(.TAG_WIDTH(TW), .SET_WIDTH(SW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .set_en(set_en), .set_tick_en(set_tick_en), .set_mode(set_mode),
        .set_addr(set_addr), .set_data(set_data), .set_hit(set_hit),
        .set_out(set_out), .set_dirty(set_dirty), .set_tag(set_tag),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [1024];
    logic        stall = 1'b0;
    int          wr_beats = 0, rd_beats = 0, mv_cycles = 0;
    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_data[$];
    logic        high_addr_seen = 1'b0;

    assign mem_ready = !stall;
    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_valid) begin
            mv_cycles++;
            if (mem_addr[31:12] != 20'h0) high_addr_seen = 1'b1;
        end
        if (mem_valid && mem_ready) begin
            if (mem_write) begin
                mem[mem_addr[11:2]] = mem_wdata;
                wlog_addr.push_back(mem_addr);
                wlog_data.push_back(mem_wdata);
                wr_beats++;
            end else begin
                rd_beats++;
            end
        end
    end

    // ---------------- set-array model (2-way, LRU by stamp, reset clears valid) ----------------
    logic [TW-1:0] sa_tag   [NSET][NWAY];
    logic          sa_valid [NSET][NWAY];
    logic          sa_dirty [NSET][NWAY];
    logic [31:0]   sa_data  [NSET][NWAY][WORDS];
    int unsigned   sa_stamp [NSET][NWAY];
    int unsigned   stamp_ctr = 0;

    logic [3:0]    m_idx;
    logic [TW-1:0] m_tag;
    logic [1:0]    m_word;
    logic          hit_found, hit_way, vict_way;

    assign m_idx  = set_addr[7:4];
    assign m_tag  = set_addr[31:8];
    assign m_word = set_addr[3:2];

    always_comb begin
        hit_found = 1'b0;
        hit_way   = 1'b0;
        for (int w = 0; w < NWAY; w++) begin
            if (sa_valid[m_idx][w] && sa_tag[m_idx][w] == m_tag) begin
                hit_found = 1'b1;
                hit_way   = w[0];
            end
        end
        vict_way = 1'b0;
        if (sa_valid[m_idx][0]) begin
            if (!sa_valid[m_idx][1] || sa_stamp[m_idx][1] < sa_stamp[m_idx][0]) vict_way = 1'b1;
        end
    end

    assign set_hit   = hit_found;
    assign set_out   = hit_found ? sa_data[m_idx][hit_way][m_word] : 32'h0;
    assign set_dirty = sa_valid[m_idx][vict_way] && sa_dirty[m_idx][vict_way];
    assign set_tag   = sa_tag[m_idx][vict_way];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NSET; s++)
                for (int w = 0; w < NWAY; w++)
                    sa_valid[s][w] <= 1'b0;
        end else if (set_en) begin
            stamp_ctr <= stamp_ctr + 1;
            if (set_mode == 2'b01 && !hit_found) begin
                sa_tag[m_idx][vict_way]           <= m_tag;
                sa_valid[m_idx][vict_way]         <= 1'b1;
                sa_dirty[m_idx][vict_way]         <= 1'b0;
                sa_data[m_idx][vict_way][m_word]  <= set_data;
                sa_stamp[m_idx][vict_way]         <= stamp_ctr + 1;
            end else if (hit_found) begin
                sa_stamp[m_idx][hit_way] <= stamp_ctr + 1;
                if (set_mode == 2'b11) begin
                    sa_data[m_idx][hit_way][m_word] <= set_data;
                    sa_dirty[m_idx][hit_way]        <= 1'b1;
                end else if (set_mode == 2'b01) begin
                    sa_data[m_idx][hit_way][m_word] <= set_data;
                end
            end
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_wb;
        int          exp_rd;
    } vec_t;

    logic [31:0] exp_wa [8] = '{32'h000, 32'h004, 32'h008, 32'h00C,
                                32'h100, 32'h104, 32'h108, 32'h10C};
    logic [31:0] exp_wd [8] = '{32'hA0A0_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003,
                                32'hDEAD_0000, 32'hB1B1_0001, 32'hDEAD_0002, 32'hDEAD_0003};
    logic [31:0] exp_sd [4] = '{32'h3030_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"},   32'(req_ready),   32'h0);
        check({tag, " resp_valid"},  32'(resp_valid),  32'h0);
        check({tag, " resp_rdata"},  resp_rdata,       32'h0);
        check({tag, " set_en"},      32'(set_en),      32'h0);
        check({tag, " set_tick_en"}, 32'(set_tick_en), 32'h0);
        check({tag, " set_mode"},    32'(set_mode),    32'h2);
        check({tag, " set_addr"},    set_addr,         32'h0);
        check({tag, " set_data"},    set_data,         32'h0);
        check({tag, " mem_valid"},   32'(mem_valid),   32'h0);
        check({tag, " mem_write"},   32'(mem_write),   32'h0);
        check({tag, " mem_addr"},    mem_addr,         32'h0);
        check({tag, " mem_wdata"},   mem_wdata,        32'h0);
    endtask

    // Called at a negedge with the controller idle; returns at a negedge back in IDLE.
    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        int n;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        n = 1;
        while (!resp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        rd  = resp_rdata;
        lat = resp_valid ? n : -1;
        @(negedge clk);
    endtask

    initial begin
        vec_t        tbl [11];
        logic [31:0] rd;
        int          lat, w0, r0, m0, n;

        tbl[0]  = '{1'b0, 32'h040, 32'h0,         32'hDEAD_0000, 8,  0, 4};
        tbl[1]  = '{1'b0, 32'h040, 32'h0,         32'hDEAD_0000, 2,  0, 0};
        tbl[2]  = '{1'b0, 32'h044, 32'h0,         32'hDEAD_0001, 2,  0, 0};
        tbl[3]  = '{1'b1, 32'h040, 32'h1234_5678, 32'h0,         2,  0, 0};
        tbl[4]  = '{1'b0, 32'h040, 32'h0,         32'h1234_5678, 2,  0, 0};
        tbl[5]  = '{1'b1, 32'h000, 32'hA0A0_0000, 32'h0,         8,  0, 4};
        tbl[6]  = '{1'b1, 32'h104, 32'hB1B1_0001, 32'h0,         8,  0, 4};
        tbl[7]  = '{1'b0, 32'h208, 32'h0,         32'hDEAD_0002, 12, 4, 4};
        tbl[8]  = '{1'b0, 32'h000, 32'h0,         32'hA0A0_0000, 12, 4, 4};
        tbl[9]  = '{1'b1, 32'h030, 32'h3030_0000, 32'h0,         8,  0, 4};
        tbl[10] = '{1'b1, 32'h130, 32'h3131_0000, 32'h0,         8,  0, 4};

        for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 + 32'(i & 3);

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
        check("ready after reset", 32'(req_ready), 32'h1);

        // Table-driven accesses
        for (int i = 0; i < 11; i++) begin
            w0 = wr_beats; r0 = rd_beats; m0 = mv_cycles;
            check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'h1);
            access(tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, lat);
            check($sformatf("v%0d rdata", i),     rd,                      tbl[i].exp_rdata);
            check($sformatf("v%0d latency", i),   32'(lat),                32'(tbl[i].exp_lat));
            check($sformatf("v%0d wb beats", i),  32'(wr_beats - w0),      32'(tbl[i].exp_wb));
            check($sformatf("v%0d fill beats", i), 32'(rd_beats - r0),     32'(tbl[i].exp_rd));
            check($sformatf("v%0d mem_valid cycles", i), 32'(mv_cycles - m0),
                  32'(tbl[i].exp_wb + tbl[i].exp_rd));
            check($sformatf("v%0d resp one cycle", i), 32'(resp_valid), 32'h0);
            $display("vector %0d: %s addr=0x%08h rdata=0x%08h lat=%0d", i,
                     tbl[i].wr ? "store" : "load", tbl[i].addr, rd, lat);
        end

        // Writeback contents of the two dirty evictions in set 0
        check("wlog size", 32'(wlog_addr.size()), 32'h8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("wb%0d addr", k), (k < wlog_addr.size()) ? wlog_addr[k] : 32'hFFFF_FFFF, exp_wa[k]);
            check($sformatf("wb%0d data", k), (k < wlog_data.size()) ? wlog_data[k] : 32'hFFFF_FFFF, exp_wd[k]);
        end

        // Memory stall in the middle of a writeback (victim 0x030 in set 3 is dirty)
        w0 = wr_beats;
        check("stall req_ready", 32'(req_ready), 32'h1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h230;
        @(negedge clk);
        req_valid = 1'b0; req_addr = '0;
        n = 0;
        while (!(mem_valid && mem_write && mem_addr == 32'h034) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall reach beat1", 32'(n < 50), 32'h1);
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d mem_valid", k), 32'(mem_valid & mem_write), 32'h1);
            check($sformatf("stall%0d mem_addr", k),  mem_addr,  32'h034);
            check($sformatf("stall%0d mem_wdata", k), mem_wdata, 32'hDEAD_0001);
            check($sformatf("stall%0d beats", k),     32'(wr_beats - w0), 32'h1);
        end
        stall = 1'b0;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall resp seen", 32'(resp_valid), 32'h1);
        check("stall rdata", resp_rdata, 32'hDEAD_0000);
        check("stall wb beats", 32'(wr_beats - w0), 32'h4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stall wb%0d addr", k), (8 + k < wlog_addr.size()) ? wlog_addr[8 + k] : 32'hFFFF_FFFF, 32'h030 + 32'(4 * k));
            check($sformatf("stall wb%0d data", k), (8 + k < wlog_data.size()) ? wlog_data[8 + k] : 32'hFFFF_FFFF, exp_sd[k]);
        end
        $display("stall sequence: load 0x00000230 rdata=0x%08h", resp_rdata);
        @(negedge clk);

        // Reset asserted during fill beat 2
        check("midfill req_ready", 32'(req_ready), 32'h1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h080;
        @(negedge clk);
        req_valid = 1'b0; req_addr = '0;
        n = 0;
        while (!(mem_valid && !mem_write && mem_addr == 32'h088) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midfill reach beat2", 32'(n < 50), 32'h1);
        reset = 1'b0;
        #1;
        check_reset_outputs("midfill");
        @(negedge clk);
        check("held reset req_ready", 32'(req_ready), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("ready after release", 32'(req_ready), 32'h1);
        r0 = rd_beats;
        access(1'b0, 32'h080, 32'h0, rd, lat);
        check("post-reset rdata", rd, 32'hDEAD_0000);
        check("post-reset latency", 32'(lat), 32'h8);
        check("post-reset fill beats", 32'(rd_beats - r0), 32'h4);
        $display("post-reset load 0x00000080 rdata=0x%08h lat=%0d", rd, lat);
        access(1'b0, 32'h08C, 32'h0, rd, lat);
        check("post-reset hit rdata", rd, 32'hDEAD_0003);
        check("post-reset hit latency", 32'(lat), 32'h2);
        $display("post-reset load 0x0000008C rdata=0x%08h lat=%0d", rd, lat);

        check("mem addr in range", 32'(high_addr_seen), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
